instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 11 +
 rtl/fetch_inflight_pipe.sv | 46 ++++
 rtl/instr_fetch.sv | 61 ++++++
 tb/tb_instr_fetch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit.
// Defaults for the fetch datapath plus the BRAM read latency.
package instr_fetch_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RESET_PC = 0;
    localparam int IMEM_RD_LAT  = 2;
    localparam int FETCH_CNT_W  = 16;

endpackage

// File: rtl/fetch_inflight_pipe.sv
// Valid/PC shift tracking fetches in flight through the BRAM,
// with a squash that kills every stage feeding the output.
module fetch_inflight_pipe
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_pc,
    input  logic              squash,
    output logic              deliver,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc
);

    logic [IMEM_RD_LAT-1:0] stg_v;
    logic [ADDR_W-1:0]      stg_pc [IMEM_RD_LAT];

    // Last stage lines up with the BRAM data of the same fetch.
    assign deliver = stg_v[IMEM_RD_LAT-1] & ~squash;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            for (int i = 0; i < IMEM_RD_LAT; i++) begin
                stg_pc[i] <= '0;
            end
        end else begin
            stg_v[0]  <= issue & ~squash;
            stg_pc[0] <= issue_pc;
            for (int i = 1; i < IMEM_RD_LAT; i++) begin
                stg_v[i]  <= stg_v[i-1] & ~squash;
                stg_pc[i] <= stg_pc[i-1];
            end
            out_valid <= deliver;
            if (deliver) begin
                out_pc <= stg_pc[IMEM_RD_LAT-1];
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, redirect handling and delivery
// of BRAM read data with its address and a running fetch count.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_choose,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [15:0]       fetch_count
);

    logic deliver;

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (pc_choose) begin
            pc <= pc + 1'b1;
        end
    end

    fetch_inflight_pipe #(
        .ADDR_W(ADDR_W)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .issue    (pc_choose),
        .issue_pc (pc),
        .squash   (redirect_valid),
        .deliver  (deliver),
        .out_valid(instr_valid),
        .out_pc   (instr_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            fetch_count <= '0;
        end else if (deliver) begin
            instr       <= imem_rdata;
            fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a 2-cycle BRAM model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_choose;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic [15:0] fetch_count;

    typedef struct {
        int         due;
        logic [9:0] pc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [9:0]  exp_pc;
    logic [31:0] rd1;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .pc_choose     (pc_choose),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [9:0] a);
        return {22'h0, a} ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        rd1        <= mem(imem_addr);
        imem_rdata <= rd1;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h",
                     nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT delivers.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d got pc=%h expected none",
                             cyc, instr_pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    exp_cnt++;
                    chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                    chk("instr", instr, mem(e.pc));
                    chk("latency_cyc", cyc, e.due);
                    chk("fetch_count", 32'(fetch_count), 32'(exp_cnt[15:0]));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid cyc=%0d got valid=0 expected pc=%h",
                         cyc, e.pc);
            end
        end
    end

    task automatic step(input logic ch, input logic rv,
                        input logic [9:0] rp);
        chk("pc", 32'(pc), 32'(exp_pc));
        chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
        pc_choose      = ch;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (rv) begin
            while (q.size() > 0 && q[$].due >= cyc + 1)
                void'(q.pop_back());
            exp_pc = rp;
        end else if (ch) begin
            q.push_back('{due: cyc + 3, pc: exp_pc});
            exp_pc = exp_pc + 10'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, 32'(instr_pc), 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_fetch_count"}, 32'(fetch_count), 32'h0);
    endtask

    initial begin
        logic [5:0] pat;
        reset          = 1'b1;
        pc_choose      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = '0;
        #2;
        chk_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;

        repeat (12) step(1'b1, 1'b0, 10'h0);

        pat = 6'b110110;
        for (int i = 5; i >= 0; i--) step(pat[i], 1'b0, 10'h0);

        step(1'b1, 1'b1, 10'h200);
        repeat (6) step(1'b1, 1'b0, 10'h0);

        step(1'b1, 1'b1, 10'h040);
        step(1'b1, 1'b1, 10'h080);
        repeat (6) step(1'b1, 1'b0, 10'h0);

        step(1'b0, 1'b1, 10'h3FE);
        step(1'b0, 1'b0, 10'h0);
        repeat (5) step(1'b1, 1'b0, 10'h0);

        step(1'b1, 1'b1, 10'h123);
        step(1'b0, 1'b0, 10'h0);
        repeat (4) step(1'b1, 1'b0, 10'h0);

        repeat (3) step(1'b1, 1'b0, 10'h0);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("midrst_async");
        q.delete();
        exp_pc  = '0;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        reset = 1'b0;
        repeat (6) step(1'b1, 1'b0, 10'h0);

        repeat (5) step(1'b0, 1'b0, 10'h0);
        chk("queue_empty", 32'(q.size()), 32'h0);
        chk("final_count", 32'(fetch_count), 32'(exp_cnt[15:0]));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
